// File: rtl/fifo_sched_pkg.sv
// ---------------------------------------------------------------------------
// fifo_sched_pkg
//   Shared types and helpers for the FIFO drain scheduler.
//   state_t     : scheduler FSM states (IDLE, SETTLE, SEND)
//   clog2_min1  : $clog2 that never returns 0, used to size index and counter
//                 fields so a degenerate parameter still yields a 1-bit vector
// ---------------------------------------------------------------------------
package fifo_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SEND   = 2'd2
  } state_t;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/fifo_drain_sched_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
//   Combinational N-way round-robin picker. Searches req starting one slot
//   after 'last' and wrapping modulo N; returns the first set index.
//   req     in  N   request vector
//   last    in  IW  index granted most recently (search starts at last+1)
//   gnt_idx out IW  selected index (0 when nothing is requested)
//   any     out 1   at least one request bit is set
// ---------------------------------------------------------------------------
module rr_pick
  import fifo_sched_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = clog2_min1(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  // The first hit wins; later hits are masked by 'any' so the loop stays a
  // simple priority chain rotated by 'last'.
  always_comb begin
    int            pos;
    logic [IW-1:0] cand;
    gnt_idx = '0;
    any     = 1'b0;
    pos     = 0;
    cand    = '0;
    for (int off = 1; off <= N; off++) begin
      pos = int'(last) + off;
      if (pos >= N) begin
        pos = pos - N;
      end
      cand = IW'(pos);
      if (!any && req[cand]) begin
        any     = 1'b1;
        gnt_idx = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_drain_sched.sv
// ---------------------------------------------------------------------------
// fifo_drain_sched
//   Round-robin drain scheduler for N_SRC FIFOs feeding one consumer. A
//   granted FIFO gets HEAD_LAT cycles for its registered head word to settle,
//   the word is captured and popped in the last settle cycle, then presented
//   on a valid/ready output tagged with its source index. At most BURST_MAX
//   consecutive words are taken from one source before re-arbitration.
//
//   i_clk         in   1            clock
//   i_rst_n       in   1            asynchronous active-low reset
//   i_src_en      in   N_SRC        per-source enable mask
//   i_src_empty   in   N_SRC        FIFO empty flags
//   i_src_data    in   N_SRC*WIDTH  FIFO head words, source k at [k*WIDTH +: WIDTH]
//   o_src_rd_incr out  N_SRC        one-hot pop strobe to the FIFOs
//   o_valid       out  1            output word valid
//   i_ready       in   1            downstream accepts the word
//   o_data        out  WIDTH        output word
//   o_src_id      out  IDW          source index of o_data
//   o_busy        out  1            scheduler is not idle
// ---------------------------------------------------------------------------
module fifo_drain_sched
  import fifo_sched_pkg::*;
#(
  parameter  int N_SRC     = 4,
  parameter  int WIDTH     = 16,
  parameter  int HEAD_LAT  = 2,
  parameter  int BURST_MAX = 4,
  localparam int IDW       = clog2_min1(N_SRC)
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic [N_SRC-1:0]       i_src_en,
  input  logic [N_SRC-1:0]       i_src_empty,
  input  logic [N_SRC*WIDTH-1:0] i_src_data,
  output logic [N_SRC-1:0]       o_src_rd_incr,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [WIDTH-1:0]       o_data,
  output logic [IDW-1:0]         o_src_id,
  output logic                   o_busy
);

  localparam int SCW = clog2_min1(HEAD_LAT);
  localparam int BCW = $clog2(BURST_MAX + 1);

  localparam logic [SCW-1:0] SETTLE_INIT = SCW'(HEAD_LAT - 1);
  localparam logic [IDW-1:0] RR_RESET    = IDW'(N_SRC - 1);

  state_t           state_q,      state_d;
  logic [SCW-1:0]   settle_cnt_q, settle_cnt_d;
  logic [IDW-1:0]   grant_q,      grant_d;
  logic [IDW-1:0]   rr_ptr_q,     rr_ptr_d;
  logic [BCW-1:0]   burst_cnt_q,  burst_cnt_d;
  logic             valid_q,      valid_d;
  logic [WIDTH-1:0] data_q,       data_d;
  logic [IDW-1:0]   src_id_q,     src_id_d;

  logic [N_SRC-1:0] req;
  logic [IDW-1:0]   pick_idx;
  logic             pick_any;
  logic             burst_more;
  logic [WIDTH-1:0] src_word [N_SRC];

  // Unpack the flat data bus so the granted head word is a plain array read.
  for (genvar k = 0; k < N_SRC; k++) begin : g_unpack
    assign src_word[k] = i_src_data[k*WIDTH +: WIDTH];
  end

  assign req = i_src_en & ~i_src_empty;

  rr_pick #(
    .N (N_SRC)
  ) u_rr_pick (
    .req     (req),
    .last    (rr_ptr_q),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  // Room for another word in this burst once the current one is accepted.
  assign burst_more = (int'(burst_cnt_q) + 1) < BURST_MAX;

  // State and datapath registers. Reset parks the pointer on the last
  // source so the first search after reset starts at source 0.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= IDLE;
      settle_cnt_q <= '0;
      grant_q      <= '0;
      rr_ptr_q     <= RR_RESET;
      burst_cnt_q  <= '0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      src_id_q     <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      grant_q      <= grant_d;
      rr_ptr_q     <= rr_ptr_d;
      burst_cnt_q  <= burst_cnt_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      src_id_q     <= src_id_d;
    end
  end

  // Next-state logic. The empty check at the end of SETTLE guards against a
  // source that drained between grant and pop; the check in SEND already
  // sees the occupancy after the pop because the FIFO flags lag by a cycle.
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    grant_d      = grant_q;
    rr_ptr_d     = rr_ptr_q;
    burst_cnt_d  = burst_cnt_q;
    valid_d      = valid_q;
    data_d       = data_q;
    src_id_d     = src_id_q;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d      = pick_idx;
          settle_cnt_d = SETTLE_INIT;
          burst_cnt_d  = '0;
          state_d      = SETTLE;
        end
      end

      SETTLE: begin
        if (settle_cnt_q != '0) begin
          settle_cnt_d = settle_cnt_q - SCW'(1);
        end else if (i_src_empty[grant_q]) begin
          rr_ptr_d = grant_q;
          state_d  = IDLE;
        end else begin
          data_d   = src_word[grant_q];
          src_id_d = grant_q;
          valid_d  = 1'b1;
          state_d  = SEND;
        end
      end

      SEND: begin
        if (i_ready) begin
          valid_d     = 1'b0;
          burst_cnt_d = burst_cnt_q + BCW'(1);
          if (burst_more && i_src_en[grant_q] && !i_src_empty[grant_q]) begin
            settle_cnt_d = SETTLE_INIT;
            state_d      = SETTLE;
          end else begin
            rr_ptr_d = grant_q;
            state_d  = IDLE;
          end
        end
      end

      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Outputs. The pop strobe is a pure decode so it falls the moment the
  // head is seen empty and can never fire while a word is being presented.
  always_comb begin
    o_src_rd_incr = '0;
    if ((state_q == SETTLE) && (settle_cnt_q == '0) && !i_src_empty[grant_q]) begin
      o_src_rd_incr[grant_q] = 1'b1;
    end
    o_busy = (state_q != IDLE);
  end

  assign o_valid  = valid_q;
  assign o_data   = data_q;
  assign o_src_id = src_id_q;

endmodule

// File: tb/tb_fifo_drain_sched.sv
// ---------------------------------------------------------------------------
// tb_fifo_drain_sched
//   Bench for fifo_drain_sched. Source FIFOs are modelled as queues whose
//   empty flag and head word are registered (they reflect a pop on the next
//   cycle). Every popped word is queued with its source and must come out of
//   the scheduler once, in order, with the right tag. Directed scenarios
//   check latency, round-robin order, backpressure, enable drop, reset and
//   short sources; a randomized phase then exercises mixed traffic.
// ---------------------------------------------------------------------------
module tb_fifo_drain_sched;

  localparam int N_SRC     = 4;
  localparam int WIDTH     = 16;
  localparam int HEAD_LAT  = 2;
  localparam int BURST_MAX = 4;
  localparam int IDW       = 2;
  localparam int DEPTH     = 8;

  typedef struct {
    int               id;
    logic [WIDTH-1:0] data;
  } word_t;

  logic                   clk       = 1'b0;
  logic                   rstN      = 1'b1;
  logic [N_SRC-1:0]       srcEn     = '0;
  logic [N_SRC-1:0]       srcEmpty  = '1;
  logic [N_SRC*WIDTH-1:0] srcData   = '0;
  logic [N_SRC-1:0]       srcRdIncr;
  logic                   oValid;
  logic                   ready     = 1'b0;
  logic [WIDTH-1:0]       oData;
  logic [IDW-1:0]         oSrcId;
  logic                   oBusy;

  logic [WIDTH-1:0] fifoQ [N_SRC][$];
  word_t            expQ[$];
  int               acceptedIds[$];
  logic [WIDTH-1:0] acceptedData[$];

  int assertCount    = 0;
  int failCount      = 0;
  int cycleCnt       = 0;
  int popCount       = 0;
  int popsPerSrc [N_SRC];
  int lastPopCycle   = -1;
  int firstValidCycle = -1;
  int validCycles    = 0;
  int totalPushed    = 0;
  int reqCycle       = 0;
  int leftover       = 0;
  logic [N_SRC-1:0] lastPopVec = '0;
  logic             prevValid  = 1'b0;
  logic [WIDTH-1:0] w0, w1;

  fifo_drain_sched #(
    .N_SRC     (N_SRC),
    .WIDTH     (WIDTH),
    .HEAD_LAT  (HEAD_LAT),
    .BURST_MAX (BURST_MAX)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_src_en      (srcEn),
    .i_src_empty   (srcEmpty),
    .i_src_data    (srcData),
    .o_src_rd_incr (srcRdIncr),
    .o_valid       (oValid),
    .i_ready       (ready),
    .o_data        (oData),
    .o_src_id      (oSrcId),
    .o_busy        (oBusy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Registered view of the source FIFOs: flags and head words follow the
  // queues one cycle after any push or pop.
  always @(posedge clk) begin
    #2;
    for (int k = 0; k < N_SRC; k++) begin
      srcEmpty[k] = (fifoQ[k].size() == 0);
      if (fifoQ[k].size() == 0) begin
        srcData[k*WIDTH +: WIDTH] = '0;
      end else begin
        srcData[k*WIDTH +: WIDTH] = fifoQ[k][0];
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Monitor: pops move words from the source queue to the scoreboard; every
  // accepted output word must match the oldest outstanding pop.
  always @(negedge clk) begin
    word_t w;
    if (srcRdIncr != '0) begin
      popCount++;
      lastPopCycle = cycleCnt;
      lastPopVec   = srcRdIncr;
      for (int k = 0; k < N_SRC; k++) begin
        if (srcRdIncr[k]) begin
          popsPerSrc[k]++;
          if (rstN) begin
            checkOutput("rd_err_pop_on_empty", fifoQ[k].size(), (fifoQ[k].size() == 0) ? 1 : fifoQ[k].size());
          end
          if (fifoQ[k].size() != 0) begin
            w.id   = k;
            w.data = fifoQ[k].pop_front();
            expQ.push_back(w);
          end
        end
      end
    end
    if (rstN) begin
      checkOutput("pop_onehot", 32'($onehot0(srcRdIncr)), 1);
      checkOutput("pop_while_valid", 32'((srcRdIncr != '0) && oValid), 0);
      if (oValid && !prevValid && firstValidCycle < 0) firstValidCycle = cycleCnt;
      if (oValid) validCycles++;
      if (oValid && ready) begin
        acceptedIds.push_back(int'(oSrcId));
        acceptedData.push_back(oData);
        if (expQ.size() == 0) begin
          checkOutput("spurious_word", expQ.size(), 1);
        end else begin
          w = expQ.pop_front();
          checkOutput("out_data", oData, w.data);
          checkOutput("out_src_id", oSrcId, w.id);
        end
      end
    end
    prevValid = oValid;
  end

  function automatic int idAt(input int i);
    return (i < acceptedIds.size()) ? acceptedIds[i] : -1;
  endfunction

  function automatic logic [WIDTH-1:0] dataAt(input int i);
    return (i < acceptedData.size()) ? acceptedData[i] : '0;
  endfunction

  task automatic applyStimulus(input logic [N_SRC-1:0] en, input logic rdy);
    srcEn = en;
    ready = rdy;
  endtask

  task automatic pushWord(input int k, input logic [WIDTH-1:0] d);
    fifoQ[k].push_back(d);
    totalPushed++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic waitAccepts(input int n, input int bound, input string tag);
    int c = 0;
    while (acceptedIds.size() < n && c < bound) begin
      tick(1);
      c++;
    end
    checkOutput(tag, acceptedIds.size(), n);
  endtask

  task automatic waitValid(input int bound, input string tag);
    int c = 0;
    while (!oValid && c < bound) begin
      tick(1);
      c++;
    end
    checkOutput(tag, 32'(oValid), 1);
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_valid"}, 32'(oValid), 0);
    checkOutput({tag, "_data"}, 32'(oData), 0);
    checkOutput({tag, "_src_id"}, 32'(oSrcId), 0);
    checkOutput({tag, "_busy"}, 32'(oBusy), 0);
    checkOutput({tag, "_pop"}, 32'(srcRdIncr), 0);
  endtask

  task automatic resetDut();
    rstN = 1'b0;
    applyStimulus('0, 1'b0);
    for (int k = 0; k < N_SRC; k++) begin
      fifoQ[k].delete();
      popsPerSrc[k] = 0;
    end
    expQ.delete();
    acceptedIds.delete();
    acceptedData.delete();
    popCount        = 0;
    totalPushed     = 0;
    firstValidCycle = -1;
    validCycles     = 0;
    lastPopCycle    = -1;
    lastPopVec      = '0;
    #1;
    checkResetOutputs("reset");
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
  endtask

  initial begin
    #1;
    resetDut();

    // Single word from source 2, latency and pulse widths.
    applyStimulus('1, 1'b1);
    reqCycle = cycleCnt;
    pushWord(2, 16'hBEEF);
    waitAccepts(1, 20, "t1_accept");
    tick(4);
    checkOutput("t1_id", idAt(0), 2);
    checkOutput("t1_data", dataAt(0), 16'hBEEF);
    checkOutput("t1_pop_vec", lastPopVec, 4'b0100);
    checkOutput("t1_pop_count", popCount, 1);
    checkOutput("t1_pop_latency", lastPopCycle - reqCycle, HEAD_LAT);
    checkOutput("t1_valid_latency", firstValidCycle - reqCycle, HEAD_LAT + 1);
    checkOutput("t1_valid_cycles", validCycles, 1);

    // Fairness: four full sources drain in bursts of BURST_MAX in turn.
    resetDut();
    applyStimulus('1, 1'b1);
    for (int k = 0; k < N_SRC; k++)
      for (int j = 0; j < 8; j++) pushWord(k, WIDTH'($urandom));
    waitAccepts(N_SRC * 8, 400, "t2_accept");
    for (int i = 0; i < N_SRC * 8; i++)
      checkOutput($sformatf("t2_id%0d", i), idAt(i), (i / BURST_MAX) % N_SRC);

    // Backpressure: word held stable, no extra pops, accepted exactly once.
    resetDut();
    applyStimulus('1, 1'b0);
    w0 = WIDTH'($urandom);
    w1 = WIDTH'($urandom);
    pushWord(0, w0);
    pushWord(0, w1);
    waitValid(20, "t3_valid");
    repeat (10) begin
      @(negedge clk);
      checkOutput("t3_hold_data", oData, w0);
      checkOutput("t3_hold_id", oSrcId, 0);
    end
    checkOutput("t3_pops_held", popCount, 1);
    tick(1);
    applyStimulus('1, 1'b1);
    tick(1);
    applyStimulus('1, 1'b0);
    tick(8);
    checkOutput("t3_single_accept", acceptedIds.size(), 1);
    checkOutput("t3_second_waiting", 32'(oValid), 1);
    applyStimulus('1, 1'b1);
    waitAccepts(2, 20, "t3_accept2");
    checkOutput("t3_pop_total", popCount, 2);

    // Enable drop mid-burst: word in flight completes, source 2 takes over.
    resetDut();
    applyStimulus('1, 1'b0);
    for (int j = 0; j < 4; j++) pushWord(1, WIDTH'($urandom));
    for (int j = 0; j < 4; j++) pushWord(2, WIDTH'($urandom));
    waitValid(20, "t4_valid");
    applyStimulus(4'b1101, 1'b1);
    waitAccepts(5, 60, "t4_accept");
    tick(6);
    checkOutput("t4_id0", idAt(0), 1);
    for (int i = 1; i < 5; i++) checkOutput($sformatf("t4_id%0d", i), idAt(i), 2);
    checkOutput("t4_src1_left", fifoQ[1].size(), 3);
    checkOutput("t4_idle", 32'(oBusy), 0);
    applyStimulus('1, 1'b1);
    waitAccepts(8, 60, "t4_accept_all");
    for (int i = 5; i < 8; i++) checkOutput($sformatf("t4_id%0d", i), idAt(i), 1);

    // Reset one cycle before the pop: no pulse, outputs clear, src0 first.
    resetDut();
    applyStimulus('1, 1'b1);
    pushWord(2, WIDTH'($urandom));
    tick(1);
    checkOutput("t5_busy_before", 32'(oBusy), 1);
    rstN = 1'b0;
    #1;
    checkResetOutputs("t5_rst");
    pushWord(0, WIDTH'($urandom));
    tick(2);
    checkOutput("t5_no_pop", popCount, 0);
    rstN = 1'b1;
    waitAccepts(2, 40, "t5_accept");
    checkOutput("t5_first_id", idAt(0), 0);
    checkOutput("t5_second_id", idAt(1), 2);

    // Short source: burst ends on empty after two words, then source 1.
    resetDut();
    applyStimulus('1, 1'b1);
    pushWord(3, WIDTH'($urandom));
    pushWord(3, WIDTH'($urandom));
    tick(1);
    for (int j = 0; j < 3; j++) pushWord(1, WIDTH'($urandom));
    waitAccepts(5, 60, "t6_accept");
    checkOutput("t6_id0", idAt(0), 3);
    checkOutput("t6_id1", idAt(1), 3);
    for (int i = 2; i < 5; i++) checkOutput($sformatf("t6_id%0d", i), idAt(i), 1);
    checkOutput("t6_src3_pops", popsPerSrc[3], 2);

    // Randomized traffic, enables and backpressure, then a full drain.
    resetDut();
    applyStimulus('1, 1'b1);
    for (int cyc = 0; cyc < 1500; cyc++) begin
      tick(1);
      if (cyc % 16 == 0) srcEn = N_SRC'($urandom);
      ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 2) == 0) begin
        int k;
        k = int'($urandom_range(0, N_SRC - 1));
        if (fifoQ[k].size() < DEPTH) pushWord(k, WIDTH'($urandom));
      end
    end
    applyStimulus('1, 1'b1);
    waitAccepts(totalPushed, 3000, "rnd_drain");
    leftover = 0;
    for (int k = 0; k < N_SRC; k++) leftover += fifoQ[k].size();
    checkOutput("rnd_fifos_empty", leftover, 0);
    checkOutput("rnd_scoreboard_empty", expQ.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
